// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: instruction width, buffer entry layout and
// the sequential PC step.
package fetch_pkg;

  localparam int unsigned ILEN   = 32;
  // Widest PC an entry can carry; narrower XLEN builds zero-pad the top bits.
  localparam int unsigned PC_W   = 32;
  localparam int unsigned PC_INC = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_unit_if.sv
// Prefetch bus bundle: redirect request, instruction-memory request/response
// channel and the instruction delivery handshake toward the decoder.
// master = prefetch unit, slave = memory plus consumer side.
interface prefetch_unit_if
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
);

  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [ILEN-1:0] imem_rdata_i;

  logic            instr_valid_o;
  logic [ILEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_ready_i;

  modport master (
    input  redirect_i, redirect_pc_i,
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output instr_valid_o, instr_o, instr_pc_o,
    input  instr_ready_i
  );

  modport slave (
    output redirect_i, redirect_pc_i,
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  instr_valid_o, instr_o, instr_pc_o,
    output instr_ready_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer, DEPTH entries (power of two), with a
// synchronous flush that empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           wdata_i,
  input  logic                   pop_i,
  output fetch_entry_t           rdata_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Qualify push/pop; a flush cancels both in the same cycle.
  always_comb begin
    do_push = push_i && !flush_i && (count != FULL);
    do_pop  = pop_i && !flush_i && (count != '0);
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Entry storage; contents are only observed behind valid_o, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  assign rdata_o = mem[rd_ptr];
  assign valid_o = (count != '0);
  assign count_o = count;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues sequential fetches, buffers in-order
// responses and handles redirects by discarding responses still in flight.
// Optional build macro PREFETCH_PERF_EN adds perf_discard_o, a saturating
// 16-bit count of dropped responses.
module prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned   XLEN     = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
  input logic             clk_i,
  input logic             rst_ni,
  prefetch_unit_if.master bus
`ifdef PREFETCH_PERF_EN
  ,
  output logic [15:0]     perf_discard_o
`endif
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_flight;
  logic            fifo_valid;
  logic            grant;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            pop;
  fetch_entry_t    wentry;
  fetch_entry_t    head;

  // Request gating, response classification and entry assembly.
  always_comb begin
    target_pc       = bus.redirect_pc_i & ~XLEN'(3);
    in_flight       = {1'b0, fifo_count} + {1'b0, outstanding};
    bus.imem_req_o  = rst_ni && !bus.redirect_i && (in_flight < LIMIT);
    grant           = bus.imem_req_o && bus.imem_gnt_i;
    // A response arriving with a redirect is stale by definition.
    rsp_keep        = bus.imem_rvalid_i && !bus.redirect_i && (discard == '0);
    rsp_drop        = bus.imem_rvalid_i && !rsp_keep;
    bus.instr_valid_o = fifo_valid && !bus.redirect_i;
    pop             = bus.instr_valid_o && bus.instr_ready_i;
    outstanding_nxt = outstanding + CW'(grant) - CW'(bus.imem_rvalid_i);
    wentry          = '0;
    wentry.pc[XLEN-1:0] = resp_pc;
    wentry.instr    = bus.imem_rdata_i;
  end

  assign bus.imem_addr_o = fetch_pc;
  assign bus.instr_o     = head.instr;
  assign bus.instr_pc_o  = head.pc[XLEN-1:0];

  // PC, outstanding and discard bookkeeping.
  // On redirect everything still in flight after this cycle is stale, so the
  // discard count becomes the next outstanding value; that also accumulates
  // any discards pending from an earlier redirect.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect_i) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        discard  <= outstanding_nxt;
      end else begin
        if (grant)    fetch_pc <= fetch_pc + XLEN'(PC_INC);
        if (rsp_keep) resp_pc  <= resp_pc + XLEN'(PC_INC);
        if (rsp_drop) discard  <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(bus.redirect_i),
    .push_i (rsp_keep),
    .wdata_i(wentry),
    .pop_i  (pop),
    .rdata_o(head),
    .valid_o(fifo_valid),
    .count_o(fifo_count)
  );

`ifdef PREFETCH_PERF_EN
  logic [15:0] perf_cnt;

  // Saturating count of dropped responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cnt <= '0;
    end else if (rsp_drop && (perf_cnt != '1)) begin
      perf_cnt <= perf_cnt + 16'd1;
    end
  end

  assign perf_discard_o = perf_cnt;
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit (XLEN=32, DEPTH=4, RESET_PC=0).
module tb_prefetch_unit;
  import fetch_pkg::*;

  logic        clk_i  = 1'b0;
  logic        rst_ni = 1'b1;
  int unsigned errors = 0;
  int unsigned checks = 0;

  prefetch_unit_if #(.XLEN(32)) bus ();

`ifdef PREFETCH_PERF_EN
  logic [15:0] perf_discard;
`endif

  prefetch_unit #(
    .XLEN    (32),
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_discard_o(perf_discard)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Memory returns a word derived from its address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Apply one cycle's inputs and let combinational outputs settle.
  task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd_addr,
                       input logic rdy, input logic redir, input logic [31:0] rpc);
    bus.imem_gnt_i    = gnt;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rv ? word_at(rd_addr) : 32'h0;
    bus.instr_ready_i = rdy;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.imem_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req_o);
    end
    checks++;
    if (bus.instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid_o);
    end
    checks++;
    if (bus.imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 00000000", bus.imem_addr_o);
    end
    step();
    rst_ni = 1'b1;
    #1;
    checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000",
                         bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pend[$];
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    exp_addr = 32'h0;
    exp_pc   = 32'h0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (pend.size() > 0) drive(1, 1, pend[0], 1, 0, 0);
      else                 drive(1, 0, 0, 1, 0, 0);
      checks++;
      if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== exp_addr) begin
        errors++; $display("FAIL stream_req[%0d]: got req=%b addr=%h expected req=1 addr=%h",
                           i, bus.imem_req_o, bus.imem_addr_o, exp_addr);
      end
      checks++;
      if (i < 2) begin
        if (bus.instr_valid_o !== 1'b0) begin
          errors++; $display("FAIL stream_latency[%0d]: got valid=%b expected 0", i, bus.instr_valid_o);
        end
      end else begin
        if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== exp_pc || bus.instr_o !== word_at(exp_pc)) begin
          errors++; $display("FAIL stream_instr[%0d]: got valid=%b pc=%h instr=%h expected 1 %h %h",
                             i, bus.instr_valid_o, bus.instr_pc_o, bus.instr_o, exp_pc, word_at(exp_pc));
        end
        exp_pc += 32'd4;
      end
      if (pend.size() > 0) void'(pend.pop_front());
      pend.push_back(exp_addr);
      exp_addr += 32'd4;
      step();
    end
  endtask

  // Reset with requests and entries still in flight.
  task automatic test_reset_mid();
    rst_ni = 1'b0;
    drive(1, 1, 32'h20, 1, 0, 0);
    checks++;
    if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got req=%b valid=%b expected 0 0",
                         bus.imem_req_o, bus.instr_valid_o);
    end
    step();
    drive(0, 0, 0, 0, 0, 0);
    rst_ni = 1'b1;
    #1;
    checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0 || bus.instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL midreset_restart: got req=%b addr=%h valid=%b expected 1 00000000 0",
                         bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pend[$];
    logic [31:0] exp_addr;
    int unsigned grants;
    exp_addr = 32'h0;
    grants   = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (pend.size() > 0) begin
        drive(1, 1, pend[0], 0, 0, 0);
        void'(pend.pop_front());
      end else begin
        drive(1, 0, 0, 0, 0, 0);
      end
      if (bus.imem_req_o === 1'b1) begin
        grants++;
        pend.push_back(exp_addr);
        exp_addr += 32'd4;
      end
      step();
    end
    checks++;
    if (grants != 4) begin
      errors++; $display("FAIL bp_grants: got %0d expected 4", grants);
    end
    drive(1, 0, 0, 1, 0, 0);
    checks++;
    if (bus.imem_req_o !== 1'b0) begin
      errors++; $display("FAIL bp_req_full: got %b expected 0", bus.imem_req_o);
    end
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h0) begin
      errors++; $display("FAIL bp_head: got valid=%b pc=%h expected 1 00000000",
                         bus.instr_valid_o, bus.instr_pc_o);
    end
    step();
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h10) begin
      errors++; $display("FAIL bp_resume: got req=%b addr=%h expected 1 00000010",
                         bus.imem_req_o, bus.imem_addr_o);
    end
    checks++;
    if (bus.instr_pc_o !== 32'h4) begin
      errors++; $display("FAIL bp_next_head: got pc=%h expected 00000004", bus.instr_pc_o);
    end
    step();
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 1, 1, 32'h100);
    checks++;
    if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL redir_gate: got req=%b valid=%b expected 0 0",
                         bus.imem_req_o, bus.instr_valid_o);
    end
    step();
    drive(1, 1, 32'h0, 1, 0, 0);
    checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin
      errors++; $display("FAIL redir_addr: got req=%b addr=%h expected 1 00000100",
                         bus.imem_req_o, bus.imem_addr_o);
    end
    step();
    drive(0, 1, 32'h4, 1, 0, 0);
    checks++;
    if (bus.instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL redir_drop1: got valid=%b expected 0", bus.instr_valid_o);
    end
    step();
    drive(0, 1, 32'h8, 1, 0, 0);
    checks++;
    if (bus.instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL redir_drop2: got valid=%b expected 0", bus.instr_valid_o);
    end
    step();
    drive(0, 1, 32'h100, 1, 0, 0);
    checks++;
    if (bus.instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL redir_drop3: got valid=%b expected 0", bus.instr_valid_o);
    end
    step();
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h100 || bus.instr_o !== word_at(32'h100)) begin
      errors++; $display("FAIL redir_first: got valid=%b pc=%h instr=%h expected 1 00000100 %h",
                         bus.instr_valid_o, bus.instr_pc_o, bus.instr_o, word_at(32'h100));
    end
`ifdef PREFETCH_PERF_EN
    checks++;
    if (perf_discard !== 16'd3) begin
      errors++; $display("FAIL perf_discard: got %0d expected 3", perf_discard);
    end
`endif
    step();
  endtask

  task automatic test_align();
    do_reset();
    drive(0, 0, 0, 0, 1, 32'h103);
    step();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin
      errors++; $display("FAIL align_addr: got req=%b addr=%h expected 1 00000100",
                         bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_collide();
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0);
    step();
    drive(1, 1, 32'h0, 1, 1, 32'h200);
    checks++;
    if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL collide_gate: got req=%b valid=%b expected 0 0",
                         bus.imem_req_o, bus.instr_valid_o);
    end
    step();
    drive(1, 1, 32'h4, 1, 0, 0);
    checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200 || bus.instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL collide_req: got req=%b addr=%h valid=%b expected 1 00000200 0",
                         bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o);
    end
    step();
    drive(0, 1, 32'h200, 1, 0, 0);
    checks++;
    if (bus.instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL collide_stale: got valid=%b pc=%h expected valid 0",
                         bus.instr_valid_o, bus.instr_pc_o);
    end
    step();
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h200 || bus.instr_o !== word_at(32'h200)) begin
      errors++; $display("FAIL collide_first: got valid=%b pc=%h instr=%h expected 1 00000200 %h",
                         bus.instr_valid_o, bus.instr_pc_o, bus.instr_o, word_at(32'h200));
    end
    step();
  endtask

  task automatic test_cumulative();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 1, 32'h300);
    step();
    drive(0, 1, 32'h0, 0, 1, 32'h400);
    step();
    drive(1, 1, 32'h4, 1, 0, 0);
    checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h400 || bus.instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL cumul_req: got req=%b addr=%h valid=%b expected 1 00000400 0",
                         bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o);
    end
    step();
    drive(0, 1, 32'h8, 1, 0, 0);
    checks++;
    if (bus.instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL cumul_drop: got valid=%b pc=%h expected valid 0",
                         bus.instr_valid_o, bus.instr_pc_o);
    end
    step();
    drive(0, 1, 32'h400, 1, 0, 0);
    checks++;
    if (bus.instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL cumul_stale: got valid=%b pc=%h expected valid 0",
                         bus.instr_valid_o, bus.instr_pc_o);
    end
    step();
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h400) begin
      errors++; $display("FAIL cumul_first: got valid=%b pc=%h expected 1 00000400",
                         bus.instr_valid_o, bus.instr_pc_o);
    end
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step();
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_top: got req=%b addr=%h expected 1 fffffffc",
                         bus.imem_req_o, bus.imem_addr_o);
    end
    step();
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    checks++;
    if (bus.imem_addr_o !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_next: got addr=%h expected 00000000", bus.imem_addr_o);
    end
    step();
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_instr: got valid=%b pc=%h expected 1 fffffffc",
                         bus.instr_valid_o, bus.instr_pc_o);
    end
    step();
  endtask

  initial begin
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.instr_ready_i = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    test_reset();
    test_stream();
    test_reset_mid();
    test_backpressure();
    test_redirect();
    test_align();
    test_collide();
    test_cumulative();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
